// File: rtl/rf_pkg.sv
// Shared types and helpers for the parametrised register file.
package rf_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

    // Index of the register reserved for the ALU overflow flag.
    function automatic int unsigned flag_idx(input int unsigned nregs);
        return nregs - 1;
    endfunction

endpackage

// File: rtl/rf_clr_seq.sv
// Clear sequencer: sweeps registers 1..NREGS-1 to zero, one per cycle.
module rf_clr_seq
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;

    // State and sweep-index registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic; busy follows the registered state so it is glitch-free.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        busy      = 1'b0;
        clr_en    = 1'b0;
        clr_idx   = idx;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = FIRST_IDX;
                end
            end
            CLEAR: begin
                busy    = 1'b1;
                clr_en  = 1'b1;
                idx_nxt = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/rf_param.sv
// Parametrised register file: hard-zero r0, overflow flag in the top register,
// optional write bypass, registered store-data port and a clear sweep.
module rf_param
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter bit          BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] di,
    input  logic             we,
    input  logic [AW-1:0]    ptr_w,
    input  logic [AW-1:0]    ptr_a,
    input  logic [WIDTH-1:0] ptr_b,
    input  logic             const_flag,
    input  logic             ovf_in,
    input  logic             clr_req,
    output logic [WIDTH-1:0] do_a,
    output logic [WIDTH-1:0] do_b,
    output logic [WIDTH-1:0] store_value,
    output logic             busy
);

    localparam logic [AW-1:0] FLAG_PTR = AW'(flag_idx(NREGS));

    logic [WIDTH-1:0] regs [NREGS];
    logic             clr_en;
    logic [AW-1:0]    clr_idx;
    logic             wr_ok;
    logic             fwd_ok;
    logic [AW-1:0]    ptr_b_idx;

    rf_clr_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    assign wr_ok     = we && !busy && (ptr_w != '0);
    assign fwd_ok    = BYPASS && wr_ok;
    assign ptr_b_idx = ptr_b[AW-1:0];

    // Array update: the sweep owns the array while clearing; otherwise the flag
    // register samples ovf_in and an explicit write (listed last) overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            store_value <= '0;
        end else begin
            store_value <= regs[ptr_w];
            if (clr_en) begin
                regs[clr_idx] <= '0;
            end else begin
                regs[FLAG_PTR] <= {{(WIDTH-1){1'b0}}, ovf_in};
                if (wr_ok) begin
                    regs[ptr_w] <= di;
                end
            end
        end
    end

    // Operand A: hard zero, then same-cycle forward, then array contents.
    always_comb begin
        do_a = regs[ptr_a];
        if (ptr_a == '0) begin
            do_a = '0;
        end else if (fwd_ok && (ptr_w == ptr_a)) begin
            do_a = di;
        end
    end

    // Operand B: constant pass-through takes priority over the register path.
    always_comb begin
        do_b = regs[ptr_b_idx];
        if (const_flag) begin
            do_b = ptr_b;
        end else if (ptr_b_idx == '0) begin
            do_b = '0;
        end else if (fwd_ok && (ptr_w == ptr_b_idx)) begin
            do_b = di;
        end
    end

endmodule

// File: tb/tb_rf_param.sv
// Directed self-checking bench for rf_param (WIDTH=8, NREGS=16, BYPASS=1).
module tb_rf_param;

    logic       clk;
    logic       rst_n;
    logic [7:0] di;
    logic       we;
    logic [3:0] ptr_w;
    logic [3:0] ptr_a;
    logic [7:0] ptr_b;
    logic       const_flag;
    logic       ovf_in;
    logic       clr_req;
    logic [7:0] do_a;
    logic [7:0] do_b;
    logic [7:0] store_value;
    logic       busy;

    int total = 0;
    int bad   = 0;

    rf_param #(
        .WIDTH  (8),
        .NREGS  (16),
        .BYPASS (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .di          (di),
        .we          (we),
        .ptr_w       (ptr_w),
        .ptr_a       (ptr_a),
        .ptr_b       (ptr_b),
        .const_flag  (const_flag),
        .ovf_in      (ovf_in),
        .clr_req     (clr_req),
        .do_a        (do_a),
        .do_b        (do_b),
        .store_value (store_value),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then changed away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; di = '0; we = 1'b0; ptr_w = '0; ptr_a = 4'd3;
        ptr_b = 8'd5; const_flag = 1'b0; ovf_in = 1'b0; clr_req = 1'b0;
        #3;
        total++; if (do_a !== 8'h00) begin bad++; $display("FAIL reset_do_a got=%h exp=%h", do_a, 8'h00); end
        total++; if (do_b !== 8'h00) begin bad++; $display("FAIL reset_do_b got=%h exp=%h", do_b, 8'h00); end
        total++; if (store_value !== 8'h00) begin bad++; $display("FAIL reset_store got=%h exp=%h", store_value, 8'h00); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        we = 1'b1; ptr_w = 4'd3; di = 8'h5A; ptr_a = 4'd3; ptr_b = 8'd3;
        #1;
        total++; if (do_a !== 8'h5A) begin bad++; $display("FAIL bypass_a got=%h exp=%h", do_a, 8'h5A); end
        total++; if (do_b !== 8'h5A) begin bad++; $display("FAIL bypass_b got=%h exp=%h", do_b, 8'h5A); end
        tick();
        we = 1'b0; di = 8'h00; ptr_b = 8'hF3;
        #1;
        total++; if (do_a !== 8'h5A) begin bad++; $display("FAIL array_a got=%h exp=%h", do_a, 8'h5A); end
        total++; if (do_b !== 8'h5A) begin bad++; $display("FAIL ptr_b_high_ignored got=%h exp=%h", do_b, 8'h5A); end
    endtask

    task automatic test_zero_const();
        we = 1'b1; ptr_w = 4'd0; di = 8'hFF; ptr_a = 4'd0;
        #1;
        total++; if (do_a !== 8'h00) begin bad++; $display("FAIL r0_no_bypass got=%h exp=%h", do_a, 8'h00); end
        tick();
        we = 1'b0; ptr_b = 8'h10;
        #1;
        total++; if (do_a !== 8'h00) begin bad++; $display("FAIL r0_hard_zero got=%h exp=%h", do_a, 8'h00); end
        total++; if (do_b !== 8'h00) begin bad++; $display("FAIL b_low_zero got=%h exp=%h", do_b, 8'h00); end
        const_flag = 1'b1; ptr_b = 8'h2C;
        #1;
        total++; if (do_b !== 8'h2C) begin bad++; $display("FAIL const_pass got=%h exp=%h", do_b, 8'h2C); end
        const_flag = 1'b0;
    endtask

    task automatic test_flag();
        ovf_in = 1'b1; ptr_a = 4'd15;
        tick();
        ovf_in = 1'b0;
        #1;
        total++; if (do_a !== 8'h01) begin bad++; $display("FAIL flag_set got=%h exp=%h", do_a, 8'h01); end
        ovf_in = 1'b1; we = 1'b1; ptr_w = 4'd15; di = 8'h80;
        tick();
        ovf_in = 1'b0; we = 1'b0; di = 8'h00;
        #1;
        total++; if (do_a !== 8'h80) begin bad++; $display("FAIL flag_write_wins got=%h exp=%h", do_a, 8'h80); end
        tick();
        total++; if (do_a !== 8'h00) begin bad++; $display("FAIL flag_resample got=%h exp=%h", do_a, 8'h00); end
    endtask

    task automatic test_store_value();
        we = 1'b1; ptr_w = 4'd2; di = 8'h11;
        tick();
        di = 8'h22;
        tick();
        we = 1'b0; di = 8'h00;
        #1;
        total++; if (store_value !== 8'h11) begin bad++; $display("FAIL store_old got=%h exp=%h", store_value, 8'h11); end
        tick();
        total++; if (store_value !== 8'h22) begin bad++; $display("FAIL store_new got=%h exp=%h", store_value, 8'h22); end
    endtask

    task automatic test_clear();
        int cnt;
        for (int i = 1; i <= 14; i++) begin
            we = 1'b1; ptr_w = 4'(i); di = 8'(8'h40 + i);
            tick();
        end
        we = 1'b0; di = 8'h00; ptr_a = 4'd4;
        #1;
        total++; if (do_a !== 8'h44) begin bad++; $display("FAIL fill_r4 got=%h exp=%h", do_a, 8'h44); end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 2) begin
                ptr_a = 4'd1; ptr_b = 8'd14;
                #1;
                total++; if (do_a !== 8'h00) begin bad++; $display("FAIL swept_r1 got=%h exp=%h", do_a, 8'h00); end
                total++; if (do_b !== 8'h4E) begin bad++; $display("FAIL unswept_r14 got=%h exp=%h", do_b, 8'h4E); end
            end
            if (cnt == 8) begin
                we = 1'b1; ptr_w = 4'd4; di = 8'h33; ptr_a = 4'd4;
                #1;
                total++; if (do_a !== 8'h00) begin bad++; $display("FAIL busy_no_bypass got=%h exp=%h", do_a, 8'h00); end
            end
            tick();
            we = 1'b0; di = 8'h00;
        end
        total++; if (cnt !== 15) begin bad++; $display("FAIL busy_cycles got=%0d exp=%0d", cnt, 15); end
        for (int i = 1; i <= 15; i++) begin
            ptr_a = 4'(i);
            #1;
            total++; if (do_a !== 8'h00) begin bad++; $display("FAIL cleared_r%0d got=%h exp=%h", i, do_a, 8'h00); end
        end
        we = 1'b1; ptr_w = 4'd5; di = 8'h77; ptr_a = 4'd5;
        #1;
        total++; if (do_a !== 8'h77) begin bad++; $display("FAIL post_clear_bypass got=%h exp=%h", do_a, 8'h77); end
        tick();
        we = 1'b0; di = 8'h00;
        #1;
        total++; if (do_a !== 8'h77) begin bad++; $display("FAIL post_clear_write got=%h exp=%h", do_a, 8'h77); end
    endtask

    task automatic test_reset_mid_sweep();
        we = 1'b1; ptr_w = 4'd6; di = 8'h66;
        tick();
        we = 1'b0; di = 8'h00; ptr_w = 4'd6; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_sweep_busy got=%b exp=%b", busy, 1'b1); end
        #2;
        rst_n = 1'b0;
        #1;
        ptr_a = 4'd6;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_abort_busy got=%b exp=%b", busy, 1'b0); end
        total++; if (do_a !== 8'h00) begin bad++; $display("FAIL reset_abort_r6 got=%h exp=%h", do_a, 8'h00); end
        total++; if (store_value !== 8'h00) begin bad++; $display("FAIL reset_abort_store got=%h exp=%h", store_value, 8'h00); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL after_reset_idle got=%b exp=%b", busy, 1'b0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_const();
        test_flag();
        test_store_value();
        test_clear();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
